// File: rtl/uart_calib_rx_pkg.sv
// Shared constants and state types for the UART calibration command receiver.
package uart_calib_rx_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned FRAME_LEN     = 6;
  localparam logic [7:0]  CMD_CH1       = 8'h01;
  localparam logic [7:0]  CMD_CH2       = 8'h02;
  localparam logic [7:0]  CMD_BOTH      = 8'h03;
  localparam logic [17:0] COEF_RESET    = 18'h003FF;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [$clog2(FRAME_LEN)-1:0] {
    P_SYNC,
    P_CMD,
    P_D2,
    P_D1,
    P_D0,
    P_CHK
  } parse_state_t;

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == CMD_CH1) || (cmd == CMD_CH2) || (cmd == CMD_BOTH);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 bit receiver: 2-FF line synchroniser, start-bit qualification and
// mid-bit sampling at 8*P clocks per bit.
module uart_rx_byte
  import uart_calib_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PRESCALE_SIZE = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_rx,
  input  logic [PRESCALE_SIZE-1:0] i_prescale,
  output logic [DATA_WIDTH-1:0]    o_byte,
  output logic                     o_byte_valid,
  output logic                     o_err,
  output logic                     o_busy
);

  localparam int unsigned CNT_W = PRESCALE_SIZE + 3;
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t                state;
  logic                     rx_meta;
  logic                     rx_sync;
  logic                     rx_prev;
  logic [PRESCALE_SIZE-1:0] prescale_eff;
  logic [PRESCALE_SIZE-1:0] prescale_lat;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         half_load;
  logic [CNT_W-1:0]         full_load;
  logic [IDX_W-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0]    shift;

  always_comb begin
    prescale_eff = (i_prescale == '0) ? PRESCALE_SIZE'(1) : i_prescale;
    half_load    = {1'b0, prescale_eff, 2'b00} - CNT_W'(1);
    full_load    = {prescale_lat, 3'b000} - CNT_W'(1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= R_IDLE;
      prescale_lat <= PRESCALE_SIZE'(1);
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_err        <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      o_err        <= 1'b0;
      case (state)
        R_IDLE: begin
          // Prescale is captured here so mid-character changes have no effect.
          if (rx_prev && !rx_sync) begin
            prescale_lat <= prescale_eff;
            cnt          <= half_load;
            state        <= R_START;
            o_busy       <= 1'b1;
          end
        end
        R_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!rx_sync) begin
            cnt     <= full_load;
            bit_idx <= '0;
            state   <= R_DATA;
          end else begin
            state  <= R_IDLE;
            o_busy <= 1'b0;
          end
        end
        R_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shift <= {rx_sync, shift[DATA_WIDTH-1:1]};
            cnt   <= full_load;
            if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
              state <= R_STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        R_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (rx_sync) begin
              o_byte       <= shift;
              o_byte_valid <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
            state  <= R_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= R_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_calib_rx.sv
// Calibration command receiver: UART bytes framed as A5,CMD,D2,D1,D0,CHK
// become an additive coefficient and command code for the ADC controller.
module uart_calib_rx
  import uart_calib_rx_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH    = 8,
  parameter int unsigned          PRESCALE_SIZE = 16,
  parameter int unsigned          COEF_WIDTH    = 18,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = DATA_WIDTH'(SYNC_BYTE_DEF),
  parameter int unsigned          TIMEOUT_CLKS  = 2000000
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_rx,
  input  logic [PRESCALE_SIZE-1:0] i_prescale,
  output logic [DATA_WIDTH-1:0]    o_byte,
  output logic                     o_byte_valid,
  output logic [DATA_WIDTH-1:0]    o_cmd,
  output logic [COEF_WIDTH-1:0]    o_coef,
  output logic                     o_coef_valid,
  output logic                     o_err,
  output logic                     o_busy
);

  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned D2_BITS = COEF_WIDTH - 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  rx_valid;
  logic                  rx_err;

  parse_state_t          state;
  logic [DATA_WIDTH-1:0] cmd_sh;
  logic [DATA_WIDTH-1:0] d2_sh;
  logic [DATA_WIDTH-1:0] d1_sh;
  logic [DATA_WIDTH-1:0] d0_sh;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  frame_ok;

  uart_rx_byte #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PRESCALE_SIZE(PRESCALE_SIZE)
  ) u_rx (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_rx        (i_rx),
    .i_prescale  (i_prescale),
    .o_byte      (rx_byte),
    .o_byte_valid(rx_valid),
    .o_err       (rx_err),
    .o_busy      (o_busy)
  );

  assign o_byte       = rx_byte;
  assign o_byte_valid = rx_valid;

  always_comb begin
    frame_ok = (rx_byte == (cmd_sh ^ d2_sh ^ d1_sh ^ d0_sh)) &&
               (d2_sh[DATA_WIDTH-1:D2_BITS] == '0);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= P_SYNC;
      cmd_sh       <= '0;
      d2_sh        <= '0;
      d1_sh        <= '0;
      d0_sh        <= '0;
      tmo_cnt      <= '0;
      o_cmd        <= '0;
      o_coef       <= COEF_WIDTH'(COEF_RESET);
      o_coef_valid <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_coef_valid <= 1'b0;
      o_err        <= 1'b0;
      // Byte, stop-bit error and timeout are mutually prioritised so a
      // single fault never yields two o_err pulses.
      if (rx_valid) begin
        tmo_cnt <= '0;
        case (state)
          P_SYNC: if (rx_byte == SYNC_BYTE) state <= P_CMD;
          P_CMD: begin
            cmd_sh <= rx_byte;
            state  <= P_D2;
          end
          P_D2: begin
            d2_sh <= rx_byte;
            state <= P_D1;
          end
          P_D1: begin
            d1_sh <= rx_byte;
            state <= P_D0;
          end
          P_D0: begin
            d0_sh <= rx_byte;
            state <= P_CHK;
          end
          P_CHK: begin
            if (frame_ok) begin
              o_cmd        <= cmd_sh;
              o_coef       <= {d2_sh[D2_BITS-1:0], d1_sh, d0_sh};
              o_coef_valid <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
            state <= P_SYNC;
          end
          default: state <= P_SYNC;
        endcase
      end else if (rx_err) begin
        o_err <= 1'b1;
        state <= P_SYNC;
      end else if (state != P_SYNC) begin
        if (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1)) begin
          o_err   <= 1'b1;
          state   <= P_SYNC;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_calib_rx.sv
// Directed bench for uart_calib_rx at prescale 4 (32 clocks per bit).
module tb_uart_calib_rx;

  localparam int unsigned BIT_CLKS = 32;
  localparam int unsigned TMO      = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [15:0] prescale = 16'd4;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic [7:0]  o_cmd;
  logic [17:0] o_coef;
  logic        o_coef_valid;
  logic        o_err;
  logic        o_busy;

  int cmp   = 0;
  int fails = 0;

  int cyc = 0;
  int n_byte = 0;
  int n_err  = 0;
  int n_coef = 0;
  int last_byte_cyc = 0;
  int last_err_cyc  = 0;

  uart_calib_rx #(
    .DATA_WIDTH   (8),
    .PRESCALE_SIZE(16),
    .COEF_WIDTH   (18),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_rx        (rx),
    .i_prescale  (prescale),
    .o_byte      (o_byte),
    .o_byte_valid(o_byte_valid),
    .o_cmd       (o_cmd),
    .o_coef      (o_coef),
    .o_coef_valid(o_coef_valid),
    .o_err       (o_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_byte_valid) begin
      n_byte = n_byte + 1;
      last_byte_cyc = cyc;
    end
    if (o_err) begin
      n_err = n_err + 1;
      last_err_cyc = cyc;
    end
    if (o_coef_valid) n_coef = n_coef + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, d2, d1, d0, chk);
    send_byte(8'hA5, 1'b1);
    send_byte(c, 1'b1);
    send_byte(d2, 1'b1);
    send_byte(d1, 1'b1);
    send_byte(d0, 1'b1);
    send_byte(chk, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    cmp++; if (o_coef !== 18'h003FF) begin fails++; $display("FAIL reset_coef: got %h want 003ff", o_coef); end
    cmp++; if (o_cmd !== 8'h00) begin fails++; $display("FAIL reset_cmd: got %h want 00", o_cmd); end
    cmp++; if (o_byte !== 8'h00) begin fails++; $display("FAIL reset_byte: got %h want 00", o_byte); end
    cmp++; if ({o_byte_valid, o_coef_valid, o_err, o_busy} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {o_byte_valid, o_coef_valid, o_err, o_busy});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int b0, e0;
    b0 = n_byte; e0 = n_err;
    send_byte(8'h5A, 1'b1);
    cmp++; if (o_byte !== 8'h5A) begin fails++; $display("FAIL byte_value: got %h want 5a", o_byte); end
    cmp++; if (n_byte - b0 !== 1) begin fails++; $display("FAIL byte_pulses: got %0d want 1", n_byte - b0); end
    cmp++; if (n_err - e0 !== 0) begin fails++; $display("FAIL byte_err: got %0d want 0", n_err - e0); end
    cmp++; if (o_busy !== 1'b0) begin fails++; $display("FAIL byte_busy_after: got %b want 0", o_busy); end
  endtask

  task automatic test_bad_checksum();
    int e0, c0;
    e0 = n_err; c0 = n_coef;
    send_frame(8'h01, 8'h02, 8'h34, 8'h56, 8'h00);
    cmp++; if (n_err - e0 !== 1) begin fails++; $display("FAIL badchk_err: got %0d want 1", n_err - e0); end
    cmp++; if (n_coef - c0 !== 0) begin fails++; $display("FAIL badchk_valid: got %0d want 0", n_coef - c0); end
    cmp++; if (o_coef !== 18'h003FF) begin fails++; $display("FAIL badchk_coef: got %h want 003ff", o_coef); end
  endtask

  task automatic test_good_frame();
    int e0, c0;
    e0 = n_err; c0 = n_coef;
    send_frame(8'h01, 8'h02, 8'h34, 8'h56, 8'h61);
    cmp++; if (o_cmd !== 8'h01) begin fails++; $display("FAIL good_cmd: got %h want 01", o_cmd); end
    cmp++; if (o_coef !== 18'h23456) begin fails++; $display("FAIL good_coef: got %h want 23456", o_coef); end
    cmp++; if (n_coef - c0 !== 1) begin fails++; $display("FAIL good_valid: got %0d want 1", n_coef - c0); end
    cmp++; if (n_err - e0 !== 0) begin fails++; $display("FAIL good_err: got %0d want 0", n_err - e0); end
  endtask

  task automatic test_glitch();
    int b0, e0;
    b0 = n_byte; e0 = n_err;
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (60) @(negedge clk);
    cmp++; if (n_byte - b0 !== 0) begin fails++; $display("FAIL glitch_byte: got %0d want 0", n_byte - b0); end
    cmp++; if (n_err - e0 !== 0) begin fails++; $display("FAIL glitch_err: got %0d want 0", n_err - e0); end
    cmp++; if (o_busy !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_reserved_bits();
    int e0, c0;
    e0 = n_err; c0 = n_coef;
    send_frame(8'h01, 8'h04, 8'h34, 8'h56, 8'h67);
    cmp++; if (n_err - e0 !== 1) begin fails++; $display("FAIL resv_err: got %0d want 1", n_err - e0); end
    cmp++; if (n_coef - c0 !== 0) begin fails++; $display("FAIL resv_valid: got %0d want 0", n_coef - c0); end
    cmp++; if (o_coef !== 18'h23456) begin fails++; $display("FAIL resv_coef: got %h want 23456", o_coef); end
  endtask

  task automatic test_stop_error();
    int e0, c0, b0;
    e0 = n_err; c0 = n_coef;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    b0 = n_byte;
    send_byte(8'h34, 1'b0);
    repeat (20) @(negedge clk);
    cmp++; if (n_err - e0 !== 1) begin fails++; $display("FAIL stop_err_count: got %0d want 1", n_err - e0); end
    cmp++; if (n_byte - b0 !== 0) begin fails++; $display("FAIL stop_byte_dropped: got %0d want 0", n_byte - b0); end
    // A fresh frame only decodes correctly if the parser resynchronised.
    send_frame(8'h02, 8'h00, 8'h12, 8'h34, 8'h24);
    cmp++; if (n_coef - c0 !== 1) begin fails++; $display("FAIL resync_valid: got %0d want 1", n_coef - c0); end
    cmp++; if (o_coef !== 18'h01234) begin fails++; $display("FAIL resync_coef: got %h want 01234", o_coef); end
    cmp++; if (o_cmd !== 8'h02) begin fails++; $display("FAIL resync_cmd: got %h want 02", o_cmd); end
    cmp++; if (n_err - e0 !== 1) begin fails++; $display("FAIL resync_err: got %0d want 1", n_err - e0); end
  endtask

  task automatic test_timeout();
    int e0, c0, k, delta;
    c0 = n_coef;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    e0 = n_err;
    k = 0;
    while (n_err == e0 && k < 1200) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    delta = last_err_cyc - last_byte_cyc;
    cmp++; if (n_err - e0 !== 1) begin fails++; $display("FAIL tmo_err_count: got %0d want 1", n_err - e0); end
    cmp++; if (delta < TMO - 2 || delta > TMO + 2) begin
      fails++; $display("FAIL tmo_latency: got %0d clks want %0d +/-2", delta, TMO);
    end
    cmp++; if (n_coef - c0 !== 0) begin fails++; $display("FAIL tmo_valid: got %0d want 0", n_coef - c0); end
  endtask

  task automatic test_reset_mid_frame();
    int e0, c0, b0;
    logic [7:0] d0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h34, 1'b1);
    d0 = 8'h56;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d0[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = d0[3];
    repeat (BIT_CLKS / 2) @(negedge clk);
    cmp++; if (o_busy !== 1'b1) begin fails++; $display("FAIL midchar_busy: got %b want 1", o_busy); end
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp++; if (o_coef !== 18'h003FF) begin fails++; $display("FAIL midrst_coef: got %h want 003ff", o_coef); end
    cmp++; if (o_cmd !== 8'h00) begin fails++; $display("FAIL midrst_cmd: got %h want 00", o_cmd); end
    cmp++; if (o_byte !== 8'h00) begin fails++; $display("FAIL midrst_byte: got %h want 00", o_byte); end
    cmp++; if ({o_byte_valid, o_coef_valid, o_err, o_busy} !== 4'b0000) begin
      fails++; $display("FAIL midrst_flags: got %b want 0000", {o_byte_valid, o_coef_valid, o_err, o_busy});
    end
    e0 = n_err; c0 = n_coef; b0 = n_byte;
    repeat (400) @(negedge clk);
    cmp++; if ((n_err - e0) + (n_coef - c0) + (n_byte - b0) !== 0) begin
      fails++; $display("FAIL midrst_quiet: got %0d pulses want 0", (n_err - e0) + (n_coef - c0) + (n_byte - b0));
    end
    send_frame(8'h03, 8'h00, 8'h00, 8'h07, 8'h04);
    cmp++; if (o_cmd !== 8'h03) begin fails++; $display("FAIL postrst_cmd: got %h want 03", o_cmd); end
    cmp++; if (o_coef !== 18'h00007) begin fails++; $display("FAIL postrst_coef: got %h want 00007", o_coef); end
    cmp++; if (n_coef - c0 !== 1) begin fails++; $display("FAIL postrst_valid: got %0d want 1", n_coef - c0); end
    cmp++; if (n_err - e0 !== 0) begin fails++; $display("FAIL postrst_err: got %0d want 0", n_err - e0); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_bad_checksum();
    test_good_frame();
    test_glitch();
    test_reserved_bits();
    test_stop_error();
    test_timeout();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule
